// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed hex driver for a common-anode seven-segment bank.
// Double-buffered nibbles, per-digit dp and blanking, leading-zero suppression,
// anti-ghosting dead time at the start of each slot, and frame-boundary updates.
module seg_scan_driver #(
   parameter int DIGITS    = 4,
   parameter int SCAN_DIV  = 100000,
   parameter int BLANK_CYC = 1000
) (
   input  logic                  CLK,
   input  logic                  RST_n,
   input  logic [4*DIGITS-1:0]   data,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     blank_in,
   input  logic                  lz_en,
   input  logic                  load,
   output logic [DIGITS-1:0]     an,
   output logic [7:0]            dispcode,
   output logic                  frame_done
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] DIV_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

   logic [CW-1:0]         div_cnt_q, div_cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [4*DIGITS-1:0]   pend_data_q, pend_data_d, act_data_q, act_data_d;
   logic [DIGITS-1:0]     pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
   logic [DIGITS-1:0]     pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
   logic                  pend_lz_q, pend_lz_d, act_lz_q, act_lz_d;
   logic [DIGITS-1:0]     an_q, an_d;
   logic [7:0]            dispcode_q, dispcode_d;
   logic                  frame_done_q, frame_done_d;
   logic                  wrap;
   logic                  upper_zero;
   logic [3:0]            nibble;

   // Hex nibble to active-low g..a pattern, dp bit left dark.
   function automatic logic [7:0] decode(input logic [3:0] n);
      case (n)
         4'h0: decode = 8'hC0;
         4'h1: decode = 8'hF9;
         4'h2: decode = 8'hA4;
         4'h3: decode = 8'hB0;
         4'h4: decode = 8'h99;
         4'h5: decode = 8'h92;
         4'h6: decode = 8'h82;
         4'h7: decode = 8'hD8;
         4'h8: decode = 8'h80;
         4'h9: decode = 8'h90;
         4'hA: decode = 8'h88;
         4'hB: decode = 8'h83;
         4'hC: decode = 8'hC6;
         4'hD: decode = 8'hA1;
         4'hE: decode = 8'h86;
         default: decode = 8'h8E;
      endcase
   endfunction

   // Scan counters; wrap marks the edge where the last digit's slot ends.
   always_comb begin
      div_cnt_d = div_cnt_q + 1'b1;
      idx_d     = idx_q;
      wrap      = 1'b0;
      if (div_cnt_q == DIV_LAST) begin
         div_cnt_d = '0;
         if (idx_q == IDX_LAST) begin
            idx_d = '0;
            wrap  = 1'b1;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
   end

   // Pending buffer follows load; active copies pending only at the frame wrap,
   // taking a coincident load directly so it is not delayed a whole frame.
   always_comb begin
      pend_data_d  = pend_data_q;
      pend_dp_d    = pend_dp_q;
      pend_blank_d = pend_blank_q;
      pend_lz_d    = pend_lz_q;
      if (load) begin
         pend_data_d  = data;
         pend_dp_d    = dp_in;
         pend_blank_d = blank_in;
         pend_lz_d    = lz_en;
      end
      act_data_d  = act_data_q;
      act_dp_d    = act_dp_q;
      act_blank_d = act_blank_q;
      act_lz_d    = act_lz_q;
      if (wrap) begin
         act_data_d  = pend_data_d;
         act_dp_d    = pend_dp_d;
         act_blank_d = pend_blank_d;
         act_lz_d    = pend_lz_d;
      end
   end

   // Next anode/segment pattern for the current slot, including dead time and suppression.
   always_comb begin
      nibble     = act_data_q[{idx_q, 2'b00} +: 4];
      upper_zero = 1'b1;
      for (int j = 0; j < DIGITS; j++) begin
         if (j >= int'(idx_q) && act_data_q[4*j +: 4] != 4'h0) upper_zero = 1'b0;
      end
      an_d       = '1;
      dispcode_d = 8'hFF;
      if (div_cnt_q >= BLANK_END) begin
         an_d[idx_q] = 1'b0;
         if (act_blank_q[idx_q]) begin
            dispcode_d = 8'hFF;
         end else if (act_lz_q && idx_q != '0 && upper_zero) begin
            dispcode_d = {~act_dp_q[idx_q], 7'h7F};
         end else begin
            dispcode_d = decode(nibble);
            if (act_dp_q[idx_q]) dispcode_d[7] = 1'b0;
         end
      end
      frame_done_d = wrap;
   end

   // State and registered outputs; reset darkens the display immediately.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         div_cnt_q    <= '0;
         idx_q        <= '0;
         pend_data_q  <= '0;
         pend_dp_q    <= '0;
         pend_blank_q <= '0;
         pend_lz_q    <= 1'b0;
         act_data_q   <= '0;
         act_dp_q     <= '0;
         act_blank_q  <= '0;
         act_lz_q     <= 1'b0;
         an_q         <= '1;
         dispcode_q   <= 8'hFF;
         frame_done_q <= 1'b0;
      end else begin
         div_cnt_q    <= div_cnt_d;
         idx_q        <= idx_d;
         pend_data_q  <= pend_data_d;
         pend_dp_q    <= pend_dp_d;
         pend_blank_q <= pend_blank_d;
         pend_lz_q    <= pend_lz_d;
         act_data_q   <= act_data_d;
         act_dp_q     <= act_dp_d;
         act_blank_q  <= act_blank_d;
         act_lz_q     <= act_lz_d;
         an_q         <= an_d;
         dispcode_q   <= dispcode_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign an         = an_q;
   assign dispcode   = dispcode_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Testbench for seg_scan_driver with DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
// A behavioural model pushes the expected registered outputs into a scoreboard
// each cycle; directed spot checks compare lit slots against decoded constants.
module tb_seg_scan_driver;

   localparam int DIGITS    = 4;
   localparam int SCAN_DIV  = 8;
   localparam int BLANK_CYC = 2;

   logic        CLK = 1'b0;
   logic        RST_n = 1'b0;
   logic [15:0] data = '0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  blank_in = '0;
   logic        lz_en = 1'b0;
   logic        load = 1'b0;
   logic [3:0]  an;
   logic [7:0]  dispcode;
   logic        frame_done;

   typedef struct packed {
      logic [3:0] an;
      logic [7:0] code;
      logic       fd;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;

   logic [15:0] p_data, a_data;
   logic [3:0]  p_dp, a_dp, p_bl, a_bl;
   logic        p_lz, a_lz;
   int          m_div, m_idx, last_idx, last_div;
   logic [7:0]  seg_rom [16];

   seg_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
      .CLK(CLK), .RST_n(RST_n), .data(data), .dp_in(dp_in), .blank_in(blank_in),
      .lz_en(lz_en), .load(load), .an(an), .dispcode(dispcode), .frame_done(frame_done)
   );

   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      m_div = 0; m_idx = 0;
      p_data = '0; p_dp = '0; p_bl = '0; p_lz = 1'b0;
      a_data = '0; a_dp = '0; a_bl = '0; a_lz = 1'b0;
      sb.delete();
   endtask

   function automatic exp_t modelOut();
      exp_t e;
      logic [3:0] nib;
      logic hide;
      e.fd = (m_div == SCAN_DIV-1) && (m_idx == DIGITS-1);
      e.an = 4'hF;
      e.code = 8'hFF;
      if (m_div >= BLANK_CYC) begin
         e.an[m_idx] = 1'b0;
         nib  = a_data[m_idx*4 +: 4];
         hide = a_lz && (m_idx > 0) && ((a_data >> (m_idx*4)) == 16'h0);
         if (a_bl[m_idx]) e.code = 8'hFF;
         else if (hide) e.code = {~a_dp[m_idx], 7'h7F};
         else begin
            e.code = seg_rom[nib];
            if (a_dp[m_idx]) e.code[7] = 1'b0;
         end
      end
      return e;
   endfunction

   task automatic applyStimulus(input logic ld);
      exp_t e;
      @(negedge CLK);
      load = ld;
      sb.push_back(modelOut());
      last_idx = m_idx;
      last_div = m_div;
      @(posedge CLK);
      if (ld) begin
         p_data = data; p_dp = dp_in; p_bl = blank_in; p_lz = lz_en;
      end
      if (m_div == SCAN_DIV-1) begin
         m_div = 0;
         if (m_idx == DIGITS-1) begin
            m_idx = 0;
            a_data = p_data; a_dp = p_dp; a_bl = p_bl; a_lz = p_lz;
         end else begin
            m_idx++;
         end
      end else begin
         m_div++;
      end
      #1;
      load = 1'b0;
      e = sb.pop_front();
      checkOutput("sb_an", {4'h0, an}, {4'h0, e.an});
      checkOutput("sb_code", dispcode, e.code);
      checkOutput("sb_frame_done", {7'h0, frame_done}, {7'h0, e.fd});
   endtask

   task automatic runSpot(input int n, input logic [31:0] codes);
      for (int k = 0; k < n; k++) begin
         applyStimulus(1'b0);
         if (last_div == 5) begin
            checkOutput("spot_an", {4'h0, an}, {4'h0, 4'hF & ~(4'b0001 << last_idx)});
            checkOutput("spot_code", dispcode, codes[last_idx*8 +: 8]);
         end
      end
   endtask

   task automatic syncTo(input int ti, input int td);
      int guard;
      guard = 0;
      while (!(m_idx == ti && m_div == td) && guard < 100) begin
         applyStimulus(1'b0);
         guard++;
      end
      checkOutput("sync_bound", {7'h0, (m_idx == ti && m_div == td)}, 8'h01);
   endtask

   initial begin
      seg_rom = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hD8,
                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
      modelReset();

      $display("[TB] reset and basic scan of 12AF");
      #12;
      checkOutput("rst_an", {4'h0, an}, 8'h0F);
      checkOutput("rst_code", dispcode, 8'hFF);
      checkOutput("rst_frame_done", {7'h0, frame_done}, 8'h00);
      @(posedge CLK); #1;
      RST_n = 1'b1;
      data = 16'h12AF;
      applyStimulus(1'b1);
      runSpot(31, 32'h0000_0000 | {8'hC0, 8'hC0, 8'hC0, 8'hC0});
      runSpot(32, {8'hF9, 8'hA4, 8'h88, 8'h8E});

      $display("[TB] leading-zero suppression");
      lz_en = 1'b1; data = 16'h0050;
      syncTo(3, 7); applyStimulus(1'b1);
      runSpot(32, {8'hFF, 8'hFF, 8'h92, 8'hC0});
      data = 16'h0000;
      syncTo(3, 7); applyStimulus(1'b1);
      runSpot(32, {8'hFF, 8'hFF, 8'hFF, 8'hC0});
      lz_en = 1'b0;
      syncTo(3, 7); applyStimulus(1'b1);
      runSpot(32, {8'hC0, 8'hC0, 8'hC0, 8'hC0});

      $display("[TB] decimal points and blanking");
      dp_in = 4'b0101; blank_in = 4'b0100; data = 16'h8888;
      syncTo(3, 7); applyStimulus(1'b1);
      runSpot(32, {8'h80, 8'hFF, 8'h80, 8'h00});

      $display("[TB] tear-free update");
      dp_in = 4'b0000; blank_in = 4'b0000; data = 16'h1111;
      syncTo(3, 7); applyStimulus(1'b1);
      runSpot(11, {8'hF9, 8'hF9, 8'hF9, 8'hF9});
      data = 16'h2222;
      applyStimulus(1'b1);
      runSpot(20, {8'hF9, 8'hF9, 8'hF9, 8'hF9});
      runSpot(32, {8'hA4, 8'hA4, 8'hA4, 8'hA4});
      data = 16'h3333;
      syncTo(3, 7); applyStimulus(1'b1);
      runSpot(32, {8'hB0, 8'hB0, 8'hB0, 8'hB0});

      $display("[TB] asynchronous reset mid-scan");
      syncTo(2, 5);
      #3;
      RST_n = 1'b0;
      #1;
      checkOutput("async_an", {4'h0, an}, 8'h0F);
      checkOutput("async_code", dispcode, 8'hFF);
      checkOutput("async_frame_done", {7'h0, frame_done}, 8'h00);
      modelReset();
      @(posedge CLK); #1;
      RST_n = 1'b1;
      runSpot(32, {8'hC0, 8'hC0, 8'hC0, 8'hC0});
      runSpot(32, {8'hC0, 8'hC0, 8'hC0, 8'hC0});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised, time-multiplexed hex display driver for the board's common-anode seven-segment bank. It holds a double-buffered copy of up to 8 hex nibbles and scans them one digit per slot. It adds per-digit blanking, per-digit decimal points, leading-zero suppression, anti-ghosting dead time and tear-free frame-boundary updates. It sits between the CPU debug/register tap and the board pins.

## Interface
- DIGITS, 4, number of digits scanned (1..8); digit 0 is least significant
- SCAN_DIV, 100000, clock cycles per digit slot (>= 2)
- BLANK_CYC, 1000, dead-time cycles at the start of each slot with all anodes off (0 <= BLANK_CYC < SCAN_DIV)
- CLK  in  1  system clock, rising edge
- RST_n  in  1  asynchronous active-low reset
- data  in  4*DIGITS  hex nibbles; digit i = data[4i+3:4i]
- dp_in  in  DIGITS  decimal point request per digit, 1 = lit
- blank_in  in  DIGITS  force digit dark (segments and dp), 1 = blank
- lz_en  in  1  leading-zero suppression enable
- load  in  1  one-cycle strobe that captures data/dp_in/blank_in/lz_en into the pending buffer
- an  out  DIGITS  anode enables, active low, at most one bit low
- dispcode  out  8  bit7 = dp, bits6..0 = g..a, active low ('0' lit)
- frame_done  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to 0

## Operation
- Decode table, hex 0..F → 8'hC0, F9, A4, B0, 99, 92, 82, D8, 80, 90, 88, 83, C6, A1, 86, 8E; bit7 is then cleared if dp is lit.
- Buffers: pending (captured on load) and active (drives the display). Pending copies into active at each frame boundary, i.e. the edge where idx wraps DIGITS-1 → 0.
  - If load coincides with a frame boundary, the newly loaded values go straight into active.
  - The active buffer never changes mid-frame.
- State: div_cnt counts 0..SCAN_DIV-1. idx counts 0..DIGITS-1, width max(1,clog2(DIGITS)).
  - At div_cnt = SCAN_DIV-1, div_cnt wraps to 0 and idx increments, wrapping to 0 after DIGITS-1.
- Per slot (idx = i, div_cnt = c):
  - If c < BLANK_CYC: an = all 1s, dispcode = 8'hFF.
  - Otherwise an bit i = 0 and all other bits = 1. dispcode is formed as follows:
    - blank_in[i] set: 8'hFF.
    - Else if lz_en is set, i > 0, and nibbles i..DIGITS-1 are all zero: segments off (bits6..0 = 1), dp follows dp_in[i].
    - Else: decode(nibble i) with dp applied.
- Digit 0 is never zero-suppressed. With DIGITS = 1, the scan is a single repeating slot and frame_done fires every SCAN_DIV cycles.

## Timing
- Reset values (async, while RST_n = 0):
  - div_cnt = 0, idx = 0, pending and active = all 0
  - an = all 1s, dispcode = 8'hFF, frame_done = 0
- an, dispcode and frame_done are registered. They reflect the (idx, div_cnt, active) state present before the previous rising edge, giving one cycle of latency.
- The first edge after reset release latches the outputs for idx = 0, c = 0, which is dark if BLANK_CYC > 0.
- frame_done is high for exactly one cycle, on the cycle after the wrap edge. It has period DIGITS*SCAN_DIV cycles.
- Data latency: load to visible takes at most one frame plus one cycle.
- Reset asserted mid-slot forces all outputs to their reset values immediately, without waiting for a clock. Scanning restarts from digit 0.

## Test plan
Bench configuration for all scenarios: DIGITS = 4, SCAN_DIV = 8, BLANK_CYC = 2.
- Reset, release, load data = 16'h12AF, then run 2 frames → during reset an = 4'b1111 and dispcode = 8'hFF. In frame 2 the slots show an 1110/8E, 1101/88, 1011/A4, 0111/F9. Each slot has 2 dark cycles then 6 lit cycles. frame_done pulses every 32 cycles.
- Leading zeros: lz_en = 1, data = 16'h0050 → digits 3 and 2 show 8'hFF, digit 1 shows 8'h92, digit 0 shows 8'hC0. With data = 0, only digit 0 shows C0. With lz_en = 0 and data = 0, all digits show C0.
- dp and blank: dp_in = 4'b0101, blank_in = 4'b0100, data = 16'h8888 → digit 0 shows 8'h00, digit 1 shows 8'h80, digit 2 shows 8'hFF, digit 3 shows 8'h80.
- Tear-free update: load 16'h1111, then load 16'h2222 during digit 1's slot → the current frame stays all 8'hF9. The next frame is all 8'hA4. Also load on the exact wrap edge → the new value appears in the immediately following frame.
- Async reset mid-scan: assert RST_n = 0 at digit 2, c = 5, off a clock edge → an = 1111, dispcode = FF and frame_done = 0 without a clock. After release, scanning restarts at digit 0 with the active buffer equal to 0.
